// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl_if
//  Description : Bundle of the MEM-stage control signals: EX/MEM input
//                bundle, upstream stall, data-memory request/response,
//                MEM/WB output bundle, branch decision and sticky error.
//                slave  - used by mem_stage_ctrl
//                master - used by whatever drives the stage (pipeline/bench)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_ctrl_if;
    // EX/MEM side
    logic [74:0] exmem_in;      // {RegWrite,MemtoReg,MemRead,MemWrite,Branch,Zero,ALUResult,WriteData,rd}
    logic        exmem_valid;
    logic        ex_mem_LD;     // 0 = hold upstream EX/MEM register
    // Data memory
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    // MEM/WB side
    logic [70:0] memwb_out;     // {RegWrite,MemtoReg,ReadData,ALUResult,rd}
    logic        memwb_valid;
    // Misc
    logic        pc_src;
    logic        err;
    logic        err_clr;

    modport slave (
        input  exmem_in, exmem_valid, mem_ready, mem_rdata, err_clr,
        output ex_mem_LD, mem_req, mem_we, mem_addr, mem_wdata,
               memwb_out, memwb_valid, pc_src, err
    );

    modport master (
        output exmem_in, exmem_valid, mem_ready, mem_rdata, err_clr,
        input  ex_mem_LD, mem_req, mem_we, mem_addr, mem_wdata,
               memwb_out, memwb_valid, pc_src, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl
//  Description : MEM pipeline stage controller. Passes non-memory
//                instructions straight to MEM/WB, issues one data-memory
//                request per load/store (stalling EX/MEM while it is
//                outstanding), flags misaligned accesses and timeouts with a
//                sticky error, and resolves taken branches.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset
//                bus   - mem_stage_ctrl_if.slave (all stage signals)
//  Parameters  : TIMEOUT - WAIT cycles allowed before giving up (1..255)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mem_stage_ctrl_if.slave bus
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic [4:0]  rd_q, rd_d;
    logic [70:0] memwb_q, memwb_d;
    logic        memwb_valid_q, memwb_valid_d;
    logic        err_q, err_d;
    logic        err_set;
    logic        ld;

    // EX/MEM field decode
    logic        in_regwrite, in_memtoreg, in_memread, in_memwrite, in_branch, in_zero;
    logic [31:0] in_alu, in_wdata;
    logic [4:0]  in_rd;
    logic        mem_op, misaligned;

    assign {in_regwrite, in_memtoreg, in_memread, in_memwrite,
            in_branch, in_zero, in_alu, in_wdata, in_rd} = bus.exmem_in;

    assign mem_op     = bus.exmem_valid & (in_memread | in_memwrite);
    assign misaligned = (in_alu[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            we_q          <= 1'b0;
            regwrite_q    <= 1'b0;
            memtoreg_q    <= 1'b0;
            rd_q          <= 5'd0;
            memwb_q       <= 71'd0;
            memwb_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            regwrite_q    <= regwrite_d;
            memtoreg_q    <= memtoreg_d;
            rd_q          <= rd_d;
            memwb_q       <= memwb_d;
            memwb_valid_q <= memwb_valid_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        regwrite_d    = regwrite_q;
        memtoreg_d    = memtoreg_q;
        rd_d          = rd_q;
        memwb_d       = memwb_q;
        memwb_valid_d = 1'b0;
        err_set       = 1'b0;
        ld            = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    ld = 1'b0;
                    if (misaligned) begin
                        // Never reaches memory; retire as a no-write bubble.
                        err_set       = 1'b1;
                        memwb_d       = {1'b0, in_memtoreg, 32'd0, in_alu, in_rd};
                        memwb_valid_d = 1'b1;
                        state_d       = DONE;
                    end else begin
                        addr_d     = in_alu;
                        wdata_d    = in_wdata;
                        we_d       = in_memwrite;
                        regwrite_d = in_regwrite;
                        memtoreg_d = in_memtoreg;
                        rd_d       = in_rd;
                        cnt_d      = 8'd0;
                        state_d    = WAIT;
                    end
                end else if (bus.exmem_valid) begin
                    memwb_d       = {in_regwrite, in_memtoreg, 32'd0, in_alu, in_rd};
                    memwb_valid_d = 1'b1;
                end
            end
            WAIT: begin
                ld = 1'b0;
                // Ready wins over the timeout when both land in the same cycle.
                if (bus.mem_ready) begin
                    memwb_d       = {regwrite_q, memtoreg_q,
                                     (we_q ? 32'd0 : bus.mem_rdata), addr_q, rd_q};
                    memwb_valid_d = 1'b1;
                    state_d       = DONE;
                end else if ((cnt_q + 8'd1) == C_TIMEOUT) begin
                    err_set       = 1'b1;
                    memwb_d       = {1'b0, memtoreg_q, 32'd0, addr_q, rd_q};
                    memwb_valid_d = 1'b1;
                    cnt_d         = cnt_q + 8'd1;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                // exmem_in still shows the instruction just retired; skip it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An error event in the same cycle as a clear keeps err set.
        if (err_set) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign bus.ex_mem_LD   = ld;
    assign bus.mem_req     = (state_q == WAIT);
    assign bus.mem_we      = (state_q == WAIT) & we_q;
    assign bus.mem_addr    = (state_q == WAIT) ? addr_q  : 32'd0;
    assign bus.mem_wdata   = (state_q == WAIT) ? wdata_q : 32'd0;
    assign bus.memwb_out   = memwb_q;
    assign bus.memwb_valid = memwb_valid_q;
    assign bus.pc_src      = (state_q == IDLE) & in_branch & in_zero & bus.exmem_valid;
    assign bus.err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_ctrl
//  Description : Self-checking bench for mem_stage_ctrl (TIMEOUT=4).
//                Stimulus pushes expected MEM/WB words into a queue; a
//                monitor pops one per memwb_valid pulse and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [70:0] exp_q[$];

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [74:0] mk(input logic rw, input logic mtr, input logic mr,
                                       input logic mw, input logic br, input logic z,
                                       input logic [31:0] alu, input logic [31:0] wd,
                                       input logic [4:0] rd);
        return {rw, mtr, mr, mw, br, z, alu, wd, rd};
    endfunction

    function automatic logic [70:0] wb(input logic rw, input logic mtr,
                                       input logic [31:0] rdata, input logic [31:0] alu,
                                       input logic [4:0] rd);
        return {rw, mtr, rdata, alu, rd};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        logic [70:0] e;
        if (reset && bus.memwb_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL memwb_unexpected: got memwb_out %h, expected no pulse", bus.memwb_out);
            end else begin
                e = exp_q.pop_front();
                chk("memwb_out", 75'(bus.memwb_out), 75'(e));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stim
        reset           = 1'b1;
        bus.exmem_in    = '0;
        bus.exmem_valid = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = '0;
        bus.err_clr     = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_mem_req",     75'(bus.mem_req),     75'(0));
        chk("rst_mem_we",      75'(bus.mem_we),      75'(0));
        chk("rst_mem_addr",    75'(bus.mem_addr),    75'(0));
        chk("rst_mem_wdata",   75'(bus.mem_wdata),   75'(0));
        chk("rst_memwb_out",   75'(bus.memwb_out),   75'(0));
        chk("rst_memwb_valid", 75'(bus.memwb_valid), 75'(0));
        chk("rst_err",         75'(bus.err),         75'(0));
        chk("rst_pc_src",      75'(bus.pc_src),      75'(0));
        chk("rst_ld",          75'(bus.ex_mem_LD),   75'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // ALU op
        @(negedge clk);
        bus.exmem_in = mk(1, 0, 0, 0, 0, 0, 32'h10, 32'h0, 5'd3);
        bus.exmem_valid = 1'b1;
        exp_q.push_back(wb(1, 0, 32'h0, 32'h10, 5'd3));
        #1;
        chk("alu_ld",  75'(bus.ex_mem_LD), 75'(1));
        chk("alu_req", 75'(bus.mem_req),   75'(0));

        // Branch taken / not taken / invalid
        @(negedge clk);
        bus.exmem_in = mk(0, 0, 0, 0, 1, 1, 32'h40, 32'h0, 5'd0);
        exp_q.push_back(wb(0, 0, 32'h0, 32'h40, 5'd0));
        #1 chk("br_taken", 75'(bus.pc_src), 75'(1));
        @(negedge clk);
        bus.exmem_in = mk(0, 0, 0, 0, 1, 0, 32'h44, 32'h0, 5'd0);
        exp_q.push_back(wb(0, 0, 32'h0, 32'h44, 5'd0));
        #1 chk("br_not_taken", 75'(bus.pc_src), 75'(0));
        @(negedge clk);
        bus.exmem_in = mk(0, 0, 0, 0, 1, 1, 32'h48, 32'h0, 5'd0);
        bus.exmem_valid = 1'b0;
        #1 chk("br_invalid", 75'(bus.pc_src), 75'(0));

        // Load, ready in the 3rd WAIT cycle
        @(negedge clk);
        bus.exmem_in = mk(1, 1, 1, 0, 0, 0, 32'h100, 32'hAAAA5555, 5'd5);
        bus.exmem_valid = 1'b1;
        bus.mem_rdata = 32'h0BAD0BAD;
        exp_q.push_back(wb(1, 1, 32'hDEADBEEF, 32'h100, 5'd5));
        #1;
        chk("ld_idle_ld",  75'(bus.ex_mem_LD), 75'(0));
        chk("ld_idle_req", 75'(bus.mem_req),   75'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hDEADBEEF;
            end
            #1;
            chk("ld_wait_req",  75'(bus.mem_req),   75'(1));
            chk("ld_wait_addr", 75'(bus.mem_addr),  75'(32'h100));
            chk("ld_wait_we",   75'(bus.mem_we),    75'(0));
            chk("ld_wait_ld",   75'(bus.ex_mem_LD), 75'(0));
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        chk("ld_done_req",  75'(bus.mem_req),   75'(0));
        chk("ld_done_ld",   75'(bus.ex_mem_LD), 75'(1));
        chk("ld_done_addr", 75'(bus.mem_addr),  75'(0));
        @(negedge clk);
        bus.exmem_valid = 1'b0;
        #1 chk("ld_idle_after", 75'(bus.mem_req), 75'(0));
        @(negedge clk);
        #1 chk("ld_no_reissue", 75'(bus.mem_req), 75'(0));

        // Store, immediate ready
        @(negedge clk);
        bus.exmem_in = mk(0, 0, 0, 1, 0, 0, 32'h204, 32'h12345678, 5'd0);
        bus.exmem_valid = 1'b1;
        bus.mem_rdata = 32'hFFFFFFFF;
        exp_q.push_back(wb(0, 0, 32'h0, 32'h204, 5'd0));
        #1 chk("st_idle_ld", 75'(bus.ex_mem_LD), 75'(0));
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        chk("st_req",   75'(bus.mem_req),   75'(1));
        chk("st_we",    75'(bus.mem_we),    75'(1));
        chk("st_addr",  75'(bus.mem_addr),  75'(32'h204));
        chk("st_wdata", 75'(bus.mem_wdata), 75'(32'h12345678));
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.exmem_valid = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        chk("st_done_we",    75'(bus.mem_we),    75'(0));
        chk("st_done_req",   75'(bus.mem_req),   75'(0));
        chk("st_done_wdata", 75'(bus.mem_wdata), 75'(0));

        // Misaligned load
        @(negedge clk);
        bus.exmem_in = mk(1, 0, 1, 0, 0, 0, 32'h102, 32'h0, 5'd7);
        bus.exmem_valid = 1'b1;
        exp_q.push_back(wb(0, 0, 32'h0, 32'h102, 5'd7));
        #1;
        chk("mis_req", 75'(bus.mem_req),   75'(0));
        chk("mis_ld",  75'(bus.ex_mem_LD), 75'(0));
        @(negedge clk);
        bus.exmem_valid = 1'b0;
        #1;
        chk("mis_done_req", 75'(bus.mem_req), 75'(0));
        chk("mis_err",      75'(bus.err),     75'(1));
        @(negedge clk);
        bus.err_clr = 1'b1;
        #1 chk("mis_err_clr_sync", 75'(bus.err), 75'(1));
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1 chk("mis_err_cleared", 75'(bus.err), 75'(0));

        // Misaligned store with err_clr in the same cycle
        @(negedge clk);
        bus.exmem_in = mk(1, 1, 0, 1, 0, 0, 32'h3, 32'h0, 5'd8);
        bus.exmem_valid = 1'b1;
        bus.err_clr = 1'b1;
        exp_q.push_back(wb(0, 1, 32'h0, 32'h3, 5'd8));
        @(negedge clk);
        bus.exmem_valid = 1'b0;
        bus.err_clr = 1'b0;
        #1 chk("err_set_wins", 75'(bus.err), 75'(1));
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1 chk("err_clr2", 75'(bus.err), 75'(0));

        // Timeout, no ready
        @(negedge clk);
        bus.exmem_in = mk(1, 1, 1, 0, 0, 0, 32'h300, 32'h0, 5'd9);
        bus.exmem_valid = 1'b1;
        exp_q.push_back(wb(0, 1, 32'h0, 32'h300, 5'd9));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("to_req", 75'(bus.mem_req), 75'(1));
        end
        @(negedge clk);
        bus.exmem_valid = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        chk("to_done_req", 75'(bus.mem_req), 75'(0));
        chk("to_err",      75'(bus.err),     75'(1));
        @(negedge clk);
        #1 chk("ready_idle_ignored", 75'(bus.mem_req), 75'(0));
        bus.mem_ready = 1'b0;
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1 chk("to_err_clr", 75'(bus.err), 75'(0));

        // Ready in the final allowed WAIT cycle
        @(negedge clk);
        bus.exmem_in = mk(1, 1, 1, 0, 0, 0, 32'h304, 32'h0, 5'd10);
        bus.exmem_valid = 1'b1;
        exp_q.push_back(wb(1, 1, 32'hCAFEF00D, 32'h304, 5'd10));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hCAFEF00D;
            end
            #1 chk("edge_req", 75'(bus.mem_req), 75'(1));
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.exmem_valid = 1'b0;
        #1;
        chk("edge_done_req", 75'(bus.mem_req), 75'(0));
        chk("edge_err",      75'(bus.err),     75'(0));

        // Asynchronous reset in the middle of WAIT
        @(negedge clk);
        bus.exmem_in = mk(1, 1, 1, 0, 0, 0, 32'h400, 32'h0, 5'd11);
        bus.exmem_valid = 1'b1;
        @(negedge clk);
        #1 chk("ar_req_before", 75'(bus.mem_req), 75'(1));
        #1 reset = 1'b0;
        #1;
        chk("ar_req_async",    75'(bus.mem_req),     75'(0));
        chk("ar_addr_async",   75'(bus.mem_addr),    75'(0));
        chk("ar_memwb_valid",  75'(bus.memwb_valid), 75'(0));
        chk("ar_memwb_out",    75'(bus.memwb_out),   75'(0));
        bus.exmem_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        #1 chk("ar_after_req", 75'(bus.mem_req), 75'(0));

        chk("sb_empty", 75'(exp_q.size()), 75'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles mem_req waits for mem_ready (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; forces the reset state immediately, independent of clk.
REQ-004 exmem_in  in  75  EX/MEM bundle: [74] RegWrite, [73] MemtoReg, [72] MemRead, [71] MemWrite, [70] Branch, [69] Zero, [68:37] ALUResult, [36:5] WriteData, [4:0] rd.
REQ-005 exmem_valid  in  1  exmem_in holds a live instruction.
REQ-006 ex_mem_LD  out  1  load enable for the upstream EX/MEM register; 0 = stall.
REQ-007 mem_req, mem_we  out  1 each  data-memory request and write strobe.
REQ-008 mem_addr, mem_wdata  out  32 each  request address and write data.
REQ-009 mem_ready  in  1  memory completes the request in this cycle.
REQ-010 mem_rdata  in  32  read data, valid when mem_ready=1.
REQ-011 memwb_out  out  71  [70] RegWrite, [69] MemtoReg, [68:37] ReadData, [36:5] ALUResult, [4:0] rd.
REQ-012 memwb_valid  out  1  memwb_out is a new result, one-cycle pulse.
REQ-013 pc_src  out  1  branch taken.
REQ-014 err  out  1  sticky error; err_clr  in  1  synchronous clear of err.

Function
REQ-015 FSM states: IDLE, WAIT, DONE.
REQ-016 mem_op = exmem_valid & (MemRead | MemWrite); misaligned = ALUResult[1:0] != 0.
REQ-017 IDLE, exmem_valid=0: no action, memwb_valid=0 next cycle.
REQ-018 IDLE, exmem_valid=1, mem_op=0: next edge loads memwb_out (ReadData=0) and pulses memwb_valid; state stays IDLE; 1-cycle latency, no stall.
REQ-019 IDLE, mem_op=1, aligned: latch address, data, and MemWrite; next state WAIT.
REQ-020 IDLE, mem_op=1, misaligned: no request issued; set err; next state DONE; memwb_out loaded with RegWrite forced 0; memwb_valid pulsed.
REQ-021 ex_mem_LD = 0 in IDLE when mem_op=1, and throughout WAIT; otherwise 1 (combinational).
REQ-022 WAIT: mem_req=1; mem_we, mem_addr, and mem_wdata are driven from the latched copy and held stable until exit; outside WAIT all are 0.
REQ-023 WAIT with mem_ready=1: capture mem_rdata (read) or 0 (write) into ReadData; load memwb_out; pulse memwb_valid next cycle; next state DONE.
REQ-024 Timeout counter clears on entering WAIT and increments each WAIT cycle without mem_ready; reaching TIMEOUT sets err, loads memwb_out with RegWrite=0, pulses memwb_valid, and moves to DONE.
REQ-025 mem_ready in the same cycle the counter reaches TIMEOUT counts as success; err is not set.
REQ-026 DONE: lasts one cycle, with ex_mem_LD=1; exmem_in is ignored (stale held instruction); next state IDLE.
REQ-027 pc_src = Branch & Zero & exmem_valid while in IDLE; 0 in WAIT and DONE.
REQ-028 mem_ready outside WAIT is ignored.
REQ-029 err_clr and an error event in the same cycle leave err=1.

Reset
REQ-030 reset=0 immediately sets state=IDLE, counter=0, and clears the latched request.
REQ-031 Under reset=0: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, memwb_out=0, memwb_valid=0, and err=0; pc_src=0 (exmem_valid is expected low).
REQ-032 Reset asserted during WAIT drops mem_req immediately; the in-flight result is discarded and memwb_valid is not pulsed.

Verification
REQ-033 ALU op: exmem_valid=1, RegWrite=1, ALUResult=0x10, rd=3 -> next cycle memwb_valid=1, memwb_out rd=3, ALUResult=0x10; ex_mem_LD stays 1.
REQ-034 Load: MemRead=1, ALUResult=0x100, mem_ready after 3 WAIT cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x100 held stable, ex_mem_LD=0 through IDLE+WAIT, then ReadData=0xDEADBEEF with one memwb_valid pulse, DONE for one cycle, and no re-issue.
REQ-035 Store: MemWrite=1, ALUResult=0x204, WriteData=0x12345678, immediate mem_ready -> mem_we=1 for exactly one cycle with the correct addr/data, and ReadData=0.
REQ-036 Misaligned: MemRead=1, ALUResult=0x102 -> mem_req never asserted, err=1, memwb_out RegWrite=0; err_clr -> err=0.
REQ-037 Timeout: TIMEOUT=4, mem_ready held 0 -> mem_req high for 4 cycles then 0, err=1, RegWrite=0; repeat with mem_ready on the 4th cycle -> err stays 0.
REQ-038 Async reset mid-WAIT: reset pulled low between edges -> mem_req=0 without waiting for clk, and no memwb_valid after release.
